// File: rtl/r2n_buffer_o.sv
// rtl/r2n_buffer_o.sv - reassembles block-ordered core results into row-major matrix rows
// Optional ping-pong slice buffering when R2N_DOUBLE_BUF_EN is defined.
module r2n_buffer_o #(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int BLOCK_SIZE = 2,
   parameter int CHUNK_SIZE = 4,
   parameter int ROW        = 8,
   parameter int COL        = 8,
   parameter int NUM_CORES  = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  en,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_r2n_buffer,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH*COL-1:0]                  out_r2n_buffer,
   output logic [$clog2(ROW)-1:0]                out_row_idx,
   output logic                                  slice_done,
   output logic                                  buffer_done
);

   localparam int SLICE_ROWS     = BLOCK_SIZE * NUM_CORES;
   localparam int CHUNKS_PER_ROW = COL / BLOCK_SIZE;
   localparam int NUM_SLICES     = ROW / SLICE_ROWS;
   localparam int CW             = WIDTH * CHUNK_SIZE;
   localparam int RW             = WIDTH * COL;
   localparam int BW             = WIDTH * BLOCK_SIZE;
   localparam int CC_W           = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
   localparam int DC_W           = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
   localparam int SI_W           = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int IDX_W          = $clog2(ROW);

   localparam logic [CC_W-1:0]  CC_LAST = CC_W'(CHUNKS_PER_ROW - 1);
   localparam logic [CC_W-1:0]  CC_ONE  = CC_W'(1);
   localparam logic [DC_W-1:0]  DC_LAST = DC_W'(SLICE_ROWS - 1);
   localparam logic [DC_W-1:0]  DC_ONE  = DC_W'(1);
   localparam logic [SI_W-1:0]  SI_LAST = SI_W'(NUM_SLICES - 1);
   localparam logic [SI_W-1:0]  SI_ONE  = SI_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE || ROW % SLICE_ROWS != 0 ||
       COL % BLOCK_SIZE != 0 || FRAC_WIDTH > WIDTH) begin : g_bad_params
      $error("r2n_buffer_o: inconsistent parameters");
   end

   // Chunks arrive in column order, so each row is a shift register that fills from the LSBs.
   function automatic logic [RW-1:0] shift_in(input logic [RW-1:0] row, input logic [BW-1:0] cols);
      return (row << BW) | RW'(cols);
   endfunction

   logic [CC_W-1:0] chunk_cnt;
   logic [DC_W-1:0] drain_cnt;
   logic [SI_W-1:0] slice_idx;
   logic            in_fire;
   logic            out_fire;
   logic            last_chunk;
   logic            last_row;
   logic            last_slice;
   logic [RW-1:0]   rows0 [SLICE_ROWS];

   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign last_chunk = (chunk_cnt == CC_LAST);
   assign last_row   = (drain_cnt == DC_LAST);
   assign last_slice = (slice_idx == SI_LAST);

`ifdef R2N_DOUBLE_BUF_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [SI_W:0] NS_CNT = (SI_W+1)'(NUM_SLICES);

   state_t          state;
   logic [1:0]      full;
   logic            wr_sel;
   logic            rd_sel;
   logic [SI_W:0]   in_cnt;
   logic [RW-1:0]   rows1 [SLICE_ROWS];

   for (genvar rr = 0; rr < SLICE_ROWS; rr++) begin : g_row
      localparam int K = rr / BLOCK_SIZE;
      localparam int R = rr % BLOCK_SIZE;
      logic [BW-1:0] cols;
      logic [RW-1:0] row_a;
      logic [RW-1:0] row_b;
      assign cols = in_r2n_buffer[(NUM_CORES-1-K)*CW + (CHUNK_SIZE-BLOCK_SIZE-R*BLOCK_SIZE)*WIDTH +: BW];
      always_ff @(posedge clk) begin
         if (in_fire && !wr_sel) row_a <= shift_in(row_a, cols);
         if (in_fire && wr_sel)  row_b <= shift_in(row_b, cols);
      end
      assign rows0[rr] = row_a;
      assign rows1[rr] = row_b;
   end

   assign in_ready       = (state == RUN) && !full[wr_sel] && (in_cnt != NS_CNT);
   assign out_valid      = (state == RUN) && full[rd_sel];
   assign out_r2n_buffer = !out_valid ? '0 : (rd_sel ? rows1[drain_cnt] : rows0[drain_cnt]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         full        <= '0;
         wr_sel      <= 1'b0;
         rd_sel      <= 1'b0;
         in_cnt      <= '0;
         chunk_cnt   <= '0;
         drain_cnt   <= '0;
         slice_idx   <= '0;
         out_row_idx <= '0;
         slice_done  <= 1'b0;
         buffer_done <= 1'b0;
      end else begin
         slice_done <= 1'b0;
         case (state)
            IDLE: if (en) state <= RUN;
            RUN: begin
               // The filling buffer is never full, so these two updates hit different buffers.
               if (in_fire) begin
                  if (last_chunk) begin
                     chunk_cnt    <= '0;
                     full[wr_sel] <= 1'b1;
                     wr_sel       <= ~wr_sel;
                     in_cnt       <= in_cnt + (SI_W+1)'(1);
                  end else begin
                     chunk_cnt <= chunk_cnt + CC_ONE;
                  end
               end
               if (out_fire) begin
                  out_row_idx <= out_row_idx + IDX_ONE;
                  if (last_row) begin
                     drain_cnt    <= '0;
                     full[rd_sel] <= 1'b0;
                     rd_sel       <= ~rd_sel;
                     slice_done   <= 1'b1;
                     if (last_slice) begin
                        state       <= DONE;
                        buffer_done <= 1'b1;
                     end else begin
                        slice_idx <= slice_idx + SI_ONE;
                     end
                  end else begin
                     drain_cnt <= drain_cnt + DC_ONE;
                  end
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
`else
   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t state;

   for (genvar rr = 0; rr < SLICE_ROWS; rr++) begin : g_row
      localparam int K = rr / BLOCK_SIZE;
      localparam int R = rr % BLOCK_SIZE;
      logic [BW-1:0] cols;
      logic [RW-1:0] row_q;
      assign cols = in_r2n_buffer[(NUM_CORES-1-K)*CW + (CHUNK_SIZE-BLOCK_SIZE-R*BLOCK_SIZE)*WIDTH +: BW];
      always_ff @(posedge clk) begin
         if (in_fire) row_q <= shift_in(row_q, cols);
      end
      assign rows0[rr] = row_q;
   end

   assign out_r2n_buffer = out_valid ? rows0[drain_cnt] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         chunk_cnt   <= '0;
         drain_cnt   <= '0;
         slice_idx   <= '0;
         out_row_idx <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         slice_done  <= 1'b0;
         buffer_done <= 1'b0;
      end else begin
         slice_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state    <= COLLECT;
                  in_ready <= 1'b1;
               end
            end
            COLLECT: begin
               if (in_fire) begin
                  if (last_chunk) begin
                     chunk_cnt <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DRAIN;
                  end else begin
                     chunk_cnt <= chunk_cnt + CC_ONE;
                  end
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  out_row_idx <= out_row_idx + IDX_ONE;
                  if (last_row) begin
                     drain_cnt  <= '0;
                     out_valid  <= 1'b0;
                     slice_done <= 1'b1;
                     if (last_slice) begin
                        state       <= DONE;
                        buffer_done <= 1'b1;
                     end else begin
                        slice_idx <= slice_idx + SI_ONE;
                        in_ready  <= 1'b1;
                        state     <= COLLECT;
                     end
                  end else begin
                     drain_cnt <= drain_cnt + DC_ONE;
                  end
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule
